// File: rtl/mux3_rr_arbiter.sv
// Three-way round-robin arbiter sharing one 3:1 datapath mux.
// The winning requester's word is captured into an output register that
// drains to one consumer over a valid/ready handshake. A new word can be
// loaded in the same cycle the old one drains, so throughput is 1 word/cycle.

// 3:1 data mux. Select 2'b11 aliases to d2 so every code picks a defined input.
module mux3 #(
    parameter int WIDTH = 8
) (
    input  logic [1:0]       sel_i,
    input  logic [WIDTH-1:0] d0_i,
    input  logic [WIDTH-1:0] d1_i,
    input  logic [WIDTH-1:0] d2_i,
    output logic [WIDTH-1:0] y_o
);

    // Pure combinational select.
    always_comb begin
        case (sel_i)
            2'b00:   y_o = d0_i;
            2'b01:   y_o = d1_i;
            default: y_o = d2_i;
        endcase
    end

endmodule

module mux3_rr_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       req,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    output logic [2:0]       gnt,
    output logic [1:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    // Registered state. last_q resets to 2 so requester 0 is first in line.
    logic [1:0]       last_q,      last_d;
    logic [1:0]       sel_q,       sel_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;

    // Arbitration results.
    logic             can_load;
    logic [1:0]       pri0, pri1, pri2;
    logic             win_vld;
    logic [1:0]       win_idx;
    logic [2:0]       gnt_w;
    logic [WIDTH-1:0] mux_y;

    // Register may take a new word when empty or being drained this cycle.
    assign can_load = !out_valid_q || out_ready;

    // Rotate the priority order so the requester after the last winner goes first.
    always_comb begin
        case (last_q)
            2'd0: begin
                pri0 = 2'd1;
                pri1 = 2'd2;
                pri2 = 2'd0;
            end
            2'd1: begin
                pri0 = 2'd2;
                pri1 = 2'd0;
                pri2 = 2'd1;
            end
            default: begin
                pri0 = 2'd0;
                pri1 = 2'd1;
                pri2 = 2'd2;
            end
        endcase
    end

    // Pick the winner; nothing is granted in reset or while the register is stalled.
    always_comb begin
        win_vld = 1'b0;
        win_idx = 2'b00;
        gnt_w   = 3'b000;
        if (rst_n && can_load) begin
            if (req[pri0]) begin
                win_vld = 1'b1;
                win_idx = pri0;
            end else if (req[pri1]) begin
                win_vld = 1'b1;
                win_idx = pri1;
            end else if (req[pri2]) begin
                win_vld = 1'b1;
                win_idx = pri2;
            end
        end
        if (win_vld) begin
            gnt_w[win_idx] = 1'b1;
        end
    end

    // Shared datapath mux steered by the current winner (00 when idle).
    mux3 #(
        .WIDTH (WIDTH)
    ) u_mux3 (
        .sel_i (win_idx),
        .d0_i  (d0),
        .d1_i  (d1),
        .d2_i  (d2),
        .y_o   (mux_y)
    );

    // Next-state: load on grant, otherwise drop valid when the consumer takes the word.
    always_comb begin
        last_d      = last_q;
        sel_d       = sel_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (win_vld) begin
            last_d      = win_idx;
            sel_d       = win_idx;
            out_valid_d = 1'b1;
            out_data_d  = mux_y;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset; reset discards any pending word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q      <= 2'd2;
            sel_q       <= 2'b00;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            last_q      <= last_d;
            sel_q       <= sel_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign gnt       = gnt_w;
    assign sel       = sel_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_mux3_rr_arbiter.sv
// Bench for mux3_rr_arbiter: directed scenarios followed by random traffic.
// A reference model predicts grants; granted words go into a scoreboard queue
// which a separate monitor drains against the DUT output handshake.
module tb_mux3_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] req = 3'b000;
    logic [7:0] d0 = 8'h00, d1 = 8'h00, d2 = 8'h00;
    logic [2:0] gnt;
    logic [1:0] sel;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] data;
        logic [1:0] idx;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    mux3_rr_arbiter #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .d0        (d0),
        .d1        (d1),
        .d2        (d2),
        .gnt       (gnt),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: last winner as an integer, register occupancy, held sel/data.
    int         m_last = 2;
    bit         m_vld  = 1'b0;
    logic [1:0] m_sel  = 2'b00;
    logic [7:0] m_data = 8'h00;
    int         eg;
    int         cand;
    logic [2:0] eg_v;
    logic [7:0] dsel;
    exp_t       e;

    // Predict this cycle's grant and the state after the coming edge.
    always @(negedge clk) begin
        eg = -1;
        if (rst_n && (!m_vld || out_ready)) begin
            for (int k = 1; k <= 3; k++) begin
                cand = (m_last + k) % 3;
                if (eg < 0 && req[cand]) eg = cand;
            end
        end
        eg_v = 3'b000;
        if (eg >= 0) eg_v[eg] = 1'b1;
        chk("gnt", {29'd0, gnt}, {29'd0, eg_v});
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_vld});
        chk("sel", {30'd0, sel}, {30'd0, m_sel});
        chk("out_data", {24'd0, out_data}, {24'd0, m_data});
        if (!rst_n) begin
            m_vld  = 1'b0;
            m_last = 2;
            m_sel  = 2'b00;
            m_data = 8'h00;
        end else if (eg >= 0) begin
            dsel   = (eg == 0) ? d0 : (eg == 1) ? d1 : d2;
            e.data = dsel;
            e.idx  = 2'(eg);
            sb_q.push_back(e);
            m_vld  = 1'b1;
            m_last = eg;
            m_sel  = 2'(eg);
            m_data = dsel;
        end else if (m_vld && out_ready) begin
            m_vld = 1'b0;
        end
    end

    // Monitor: whatever the DUT presents must be the oldest granted word.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
        end else if (out_valid) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_empty: got out_valid=1 with data %0h expected no word at %0t",
                         out_data, $time);
            end else begin
                chk("sb_data", {24'd0, out_data}, {24'd0, sb_q[0].data});
                chk("sb_sel", {30'd0, sel}, {30'd0, sb_q[0].idx});
                if (out_ready) void'(sb_q.pop_front());
            end
        end
    end

    task automatic drive(input logic r, input logic [2:0] q, input logic rdy,
                         input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        @(posedge clk);
        #1;
        rst_n     = r;
        req       = q;
        out_ready = rdy;
        d0        = a;
        d1        = b;
        d2        = c;
    endtask

    initial begin
        // Reset held two cycles with all requesting.
        rst_n = 1'b0; req = 3'b111; out_ready = 1'b1;
        drive(1'b0, 3'b111, 1'b1, 8'hA0, 8'hB1, 8'hC2);
        // Round robin 0,1,2,0.
        repeat (4) drive(1'b1, 3'b111, 1'b1, 8'hA0, 8'hB1, 8'hC2);
        // Backpressure with A0 held, then release.
        repeat (3) drive(1'b1, 3'b010, 1'b0, 8'hA0, 8'hB1, 8'hC2);
        drive(1'b1, 3'b010, 1'b1, 8'hA0, 8'hB1, 8'hC2);
        // Single requester 2, then requester 0 (after 2 was last).
        drive(1'b1, 3'b100, 1'b1, 8'hA0, 8'hB1, 8'h5C);
        drive(1'b1, 3'b001, 1'b1, 8'hA0, 8'hB1, 8'h5C);
        // Drain only.
        repeat (2) drive(1'b1, 3'b000, 1'b1, 8'hA0, 8'hB1, 8'h5C);
        // Load C2, reset mid-transfer, then req=011 must pick 0.
        drive(1'b1, 3'b100, 1'b0, 8'hA0, 8'hB1, 8'hC2);
        drive(1'b1, 3'b000, 1'b0, 8'hA0, 8'hB1, 8'hC2);
        drive(1'b0, 3'b111, 1'b0, 8'hA0, 8'hB1, 8'hC2);
        repeat (3) drive(1'b1, 3'b011, 1'b1, 8'h11, 8'h22, 8'h33);
        // Random traffic with occasional reset and backpressure.
        for (int n = 0; n < 3000; n++) begin
            drive(($urandom_range(0, 59) != 0), 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), 8'($urandom));
        end
        drive(1'b1, 3'b000, 1'b1, 8'h00, 8'h00, 8'h00);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
